// File: rtl/norm_round_ctrl.sv
// FP adder back-end sequencer: drives the external normalizer, rounds to nearest-even,
// fixes up the exponent and emits a packed IEEE-754 single with overflow/underflow/zero flags.
module norm_round_ctrl #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic                    in_carry,
    input  logic [FRAC_W+3:0]       in_mant,
    output logic                    norm_en,
    output logic                    norm_shift_mode,
    output logic [4:0]              norm_shift_amt,
    output logic [FRAC_W+3:0]       norm_mant,
    input  logic [FRAC_W+3:0]       norm_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_ovf,
    output logic                    out_unf,
    output logic                    out_zero
);

    localparam int unsigned MAN_W = FRAC_W + 4;
    localparam int unsigned LZC_W = 5;
    localparam int unsigned EW    = EXP_W + 1;
    localparam int unsigned RW    = EXP_W + FRAC_W + 1;

    typedef enum logic [2:0] {StIdle, StShift, StRound, StAdj, StDone} state_e;

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               carry_q, carry_d;
    logic [MAN_W-1:0]   mant_q, mant_d;
    logic [LZC_W-1:0]   lzc_q, lzc_d;
    logic [MAN_W-1:0]   m_q, m_d;
    logic [EW-1:0]      e_q, e_d;
    logic [RW-1:0]      res_q, res_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               zero_q, zero_d;

    logic [LZC_W-1:0]   lzc_c;
    logic               lzc_found;
    logic [EW-1:0]      exp_ext, lzc_ext, e_inc, e_dec, e_adj, exp_max;
    logic               rup;
    logic               frac_co;
    logic [FRAC_W-1:0]  frac_rnd;
    logic               rnd_adj;

    // Leading-zero count of the incoming sum; an all-zero sum saturates at MAN_W-1.
    always_comb begin
        lzc_c     = LZC_W'(MAN_W - 1);
        lzc_found = 1'b0;
        for (int i = MAN_W - 1; i >= 0; i--) begin
            if (!lzc_found && in_mant[i]) begin
                lzc_c     = LZC_W'(MAN_W - 1 - i);
                lzc_found = 1'b1;
            end
        end
    end

    // Exponent math is one bit wider so wrap past the all-ones code is visible.
    always_comb begin
        exp_ext = {1'b0, exp_q};
        lzc_ext = EW'(lzc_q);
        exp_max = {1'b0, {EXP_W{1'b1}}};
        e_inc   = exp_ext + EW'(1);
        e_dec   = exp_ext - lzc_ext;
        e_adj   = e_q + EW'(1);
    end

    // Round-half-even on the captured mantissa; carry out of the full significand means ADJ.
    always_comb begin
        rup                 = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
        {frac_co, frac_rnd} = {1'b0, m_q[FRAC_W+2:3]} + (FRAC_W + 1)'(rup);
        rnd_adj             = frac_co & m_q[MAN_W-1];
    end

    always_comb begin
        state_d         = state_q;
        sign_d          = sign_q;
        exp_d           = exp_q;
        carry_d         = carry_q;
        mant_d          = mant_q;
        lzc_d           = lzc_q;
        m_d             = m_q;
        e_d             = e_q;
        res_d           = res_q;
        ovf_d           = ovf_q;
        unf_d           = unf_q;
        zero_d          = zero_q;
        in_ready        = (state_q == StIdle);
        out_valid       = (state_q == StDone);
        norm_en         = 1'b0;
        norm_shift_mode = 1'b0;
        norm_shift_amt  = '0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = in_exp;
                    carry_d = in_carry;
                    mant_d  = in_mant;
                    lzc_d   = lzc_c;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                norm_en         = 1'b1;
                norm_shift_mode = ~carry_q;
                norm_shift_amt  = carry_q ? '0 : lzc_q;
                m_d             = norm_result;
                e_d             = carry_q ? e_inc : e_dec;
                if (mant_q == '0 && !carry_q) begin
                    res_d   = '0;
                    zero_d  = 1'b1;
                    state_d = StDone;
                end else if (carry_q && e_inc >= exp_max) begin
                    res_d   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    ovf_d   = 1'b1;
                    state_d = StDone;
                end else if (!carry_q && exp_ext <= lzc_ext) begin
                    res_d   = {sign_q, {(RW - 1){1'b0}}};
                    unf_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StRound;
                end
            end
            StRound: begin
                if (rnd_adj) begin
                    state_d = StAdj;
                end else begin
                    res_d   = {sign_q, e_q[EXP_W-1:0], frac_rnd};
                    state_d = StDone;
                end
            end
            StAdj: begin
                if (e_adj >= exp_max) begin
                    res_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    ovf_d = 1'b1;
                end else begin
                    res_d = {sign_q, e_adj[EXP_W-1:0], {FRAC_W{1'b0}}};
                end
                e_d     = e_adj;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            carry_q <= 1'b0;
            mant_q  <= '0;
            lzc_q   <= '0;
            m_q     <= '0;
            e_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            carry_q <= carry_d;
            mant_q  <= mant_d;
            lzc_q   <= lzc_d;
            m_q     <= m_d;
            e_q     <= e_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            zero_q  <= zero_d;
        end
    end

    assign norm_mant  = mant_q;
    assign out_result = res_q;
    assign out_ovf    = ovf_q;
    assign out_unf    = unf_q;
    assign out_zero   = zero_q;

endmodule

// File: tb/tb_norm_round_ctrl.sv
// Self-checking bench for norm_round_ctrl: directed cases, backpressure, mid-op reset and
// randomized operations against a value-level round-to-nearest-even model.
module tb_norm_round_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic        in_carry;
    logic [26:0] in_mant;
    logic        norm_en;
    logic        norm_shift_mode;
    logic [4:0]  norm_shift_amt;
    logic [26:0] norm_mant;
    logic [26:0] norm_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        out_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    norm_round_ctrl #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sign         (in_sign),
        .in_exp          (in_exp),
        .in_carry        (in_carry),
        .in_mant         (in_mant),
        .norm_en         (norm_en),
        .norm_shift_mode (norm_shift_mode),
        .norm_shift_amt  (norm_shift_amt),
        .norm_mant       (norm_mant),
        .norm_result     (norm_result),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_ovf         (out_ovf),
        .out_unf         (out_unf),
        .out_zero        (out_zero)
    );

    // Normalizer model: right-by-1 folds the carry in and keeps sticky; left shift is exact.
    assign norm_result = !norm_en ? 27'd0 :
                         (norm_shift_mode ? (norm_mant << norm_shift_amt)
                                          : {1'b1, norm_mant[26:2], norm_mant[1] | norm_mant[0]});

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        zero;
        logic [3:0]  lat;
    } exp_t;

    typedef struct {
        logic        s;
        logic [7:0]  ex;
        logic        c;
        logic [26:0] mt;
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
        logic        chk;
        logic        mode;
        logic [4:0]  amt;
    } vec_t;

    // Value-level reference: treat {carry, mant} as an integer, place the MSB, round RNE.
    function automatic exp_t ref_model(input logic s, input logic [7:0] ex, input logic c,
                                       input logic [26:0] mt);
        exp_t   r;
        longint v, kept, rem, half;
        int     p, e;
        r     = '0;
        r.lat = 4'd3;
        v     = longint'({c, mt});
        if (v == 0) begin
            r.zero = 1'b1;
            r.lat  = 4'd2;
            return r;
        end
        p = 27;
        while (((v >> p) & 1) == 0) p--;
        e = int'(ex) + p - 26;
        if (c && e >= 255) begin
            r.ovf = 1'b1;
            r.res = {s, 8'hFF, 23'd0};
            r.lat = 4'd2;
            return r;
        end
        if (!c && e <= 0) begin
            r.unf = 1'b1;
            r.res = {s, 31'd0};
            r.lat = 4'd2;
            return r;
        end
        if (p >= 24) begin
            kept = v >> (p - 23);
            rem  = v & ((longint'(1) << (p - 23)) - 1);
            half = longint'(1) << (p - 24);
            if (rem > half || (rem == half && kept[0])) kept = kept + 1;
        end else begin
            kept = v << (23 - p);
        end
        if (kept == (longint'(1) << 24)) begin
            kept  = kept >> 1;
            e     = e + 1;
            r.lat = 4'd4;
        end
        if (e >= 255) begin
            r.ovf = 1'b1;
            r.res = {s, 8'hFF, 23'd0};
        end else begin
            r.res = {s, 8'(e), 23'(kept)};
        end
        return r;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            $display("FAIL wait_idle: in_ready=%0b after %0d cycles, required 1", in_ready, n);
            $fatal(1);
        end
    endtask

    // Issue one operation and follow it until out_valid (bounded); out_ready is left alone.
    task automatic run_op(input logic s, input logic [7:0] ex, input logic c,
                          input logic [26:0] mt, output exp_t got, output logic t_en,
                          output logic t_mode, output logic [4:0] t_amt,
                          output logic [26:0] t_nm);
        wait_idle();
        in_sign  = s;
        in_exp   = ex;
        in_carry = c;
        in_mant  = mt;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mant  = 27'($urandom);
        in_exp   = 8'($urandom);
        t_en     = norm_en;
        t_mode   = norm_shift_mode;
        t_amt    = norm_shift_amt;
        t_nm     = norm_mant;
        got      = '0;
        got.lat  = 4'd1;
        while (!out_valid && got.lat < 4'd10) begin
            @(posedge clk); #1;
            got.lat++;
        end
        got.res  = out_result;
        got.ovf  = out_ovf;
        got.unf  = out_unf;
        got.zero = out_zero;
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_carry  = 1'b0;
        in_mant   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, norm_en, norm_shift_mode} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctl: got ready/valid/en/mode=%b required 1000",
                     {in_ready, out_valid, norm_en, norm_shift_mode});
        end
        checks++;
        if ({norm_shift_amt, norm_mant, out_result} !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: got amt=%0d mant=%h result=%h required all 0",
                     norm_shift_amt, norm_mant, out_result);
        end
        checks++;
        if ({out_ovf, out_unf, out_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000", {out_ovf, out_unf, out_zero});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vec_t        v[9];
        exp_t        got;
        logic        t_en, t_mode;
        logic [4:0]  t_amt;
        logic [26:0] t_nm;
        v[0] = '{1'b0, 8'd127, 1'b0, 27'h4000000, 32'h3F800000, 3'b000, 3, 1'b1, 1'b1, 5'd0};
        v[1] = '{1'b0, 8'd127, 1'b1, 27'h4000000, 32'h40400000, 3'b000, 3, 1'b1, 1'b0, 5'd0};
        v[2] = '{1'b0, 8'd130, 1'b0, 27'h0800000, 32'h3F800000, 3'b000, 3, 1'b1, 1'b1, 5'd3};
        v[3] = '{1'b0, 8'd127, 1'b0, 27'h7FFFFFC, 32'h40000000, 3'b000, 4, 1'b1, 1'b1, 5'd0};
        v[4] = '{1'b0, 8'd254, 1'b1, 27'h4000000, 32'h7F800000, 3'b100, 2, 1'b1, 1'b0, 5'd0};
        v[5] = '{1'b1, 8'd100, 1'b0, 27'h0000000, 32'h00000000, 3'b001, 2, 1'b0, 1'b1, 5'd0};
        v[6] = '{1'b1, 8'd3,   1'b0, 27'h0100000, 32'h80000000, 3'b010, 2, 1'b1, 1'b1, 5'd6};
        v[7] = '{1'b0, 8'd7,   1'b0, 27'h0100000, 32'h00800000, 3'b000, 3, 1'b1, 1'b1, 5'd6};
        v[8] = '{1'b0, 8'd254, 1'b0, 27'h7FFFFFC, 32'h7F800000, 3'b100, 4, 1'b1, 1'b1, 5'd0};
        for (int i = 0; i < 9; i++) begin
            run_op(v[i].s, v[i].ex, v[i].c, v[i].mt, got, t_en, t_mode, t_amt, t_nm);
            checks++;
            if (got.res !== v[i].res) begin
                errors++;
                $display("FAIL dir%0d_result: got %h required %h", i, got.res, v[i].res);
            end
            checks++;
            if ({got.ovf, got.unf, got.zero} !== v[i].fl) begin
                errors++;
                $display("FAIL dir%0d_flags: got ovf/unf/zero=%b required %b", i,
                         {got.ovf, got.unf, got.zero}, v[i].fl);
            end
            checks++;
            if (int'(got.lat) !== v[i].lat) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d required %0d", i, got.lat, v[i].lat);
            end
            checks++;
            if ({t_en, t_nm} !== {1'b1, v[i].mt}) begin
                errors++;
                $display("FAIL dir%0d_norm_en_mant: got en=%b mant=%h required en=1 mant=%h",
                         i, t_en, t_nm, v[i].mt);
            end
            if (v[i].chk) begin
                checks++;
                if ({t_mode, t_amt} !== {v[i].mode, v[i].amt}) begin
                    errors++;
                    $display("FAIL dir%0d_norm_ctl: got mode=%b amt=%0d required mode=%b amt=%0d",
                             i, t_mode, t_amt, v[i].mode, v[i].amt);
                end
            end
            release_op();
            checks++;
            if ({in_ready, out_valid, norm_en} !== 3'b100) begin
                errors++;
                $display("FAIL dir%0d_post: got ready/valid/en=%b required 100", i,
                         {in_ready, out_valid, norm_en});
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t        got;
        logic        t_en, t_mode;
        logic [4:0]  t_amt;
        logic [26:0] t_nm;
        run_op(1'b0, 8'd127, 1'b0, 27'h4000000, got, t_en, t_mode, t_amt, t_nm);
        for (int i = 0; i < 5; i++) begin
            // Unwanted operand offered while the result is still held.
            in_valid = 1'b1;
            in_exp   = 8'd1;
            in_mant  = 27'h1234567;
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, out_result, out_ovf, out_unf, out_zero}
                    !== {1'b1, 1'b0, 32'h3F800000, 3'b000}) begin
                errors++;
                $display("FAIL hold%0d: got valid=%b ready=%b result=%h flags=%b required 1 0 3f800000 000",
                         i, out_valid, in_ready, out_result, {out_ovf, out_unf, out_zero});
            end
        end
        in_valid = 1'b0;
        release_op();
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, norm_en} !== 3'b100) begin
            errors++;
            $display("FAIL hold_release: got ready/valid/en=%b required 100",
                     {in_ready, out_valid, norm_en});
        end
    endtask

    task automatic test_reset_mid_op();
        exp_t        got;
        logic        t_en, t_mode;
        logic [4:0]  t_amt;
        logic [26:0] t_nm;
        int          seen;
        wait_idle();
        in_sign  = 1'b0;
        in_exp   = 8'd127;
        in_carry = 1'b0;
        in_mant  = 27'h7FFFFFC;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, norm_en} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_async: got ready/valid/en=%b required 100",
                     {in_ready, out_valid, norm_en});
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrst_quiet: got %0d cycles with output/busy required 0", seen);
        end
        run_op(1'b1, 8'd130, 1'b0, 27'h0800000, got, t_en, t_mode, t_amt, t_nm);
        checks++;
        if ({got.res, got.ovf, got.unf, got.zero, got.lat} !== {32'hBF800000, 3'b000, 4'd3}) begin
            errors++;
            $display("FAIL midrst_next: got result=%h flags=%b lat=%0d required bf800000 000 3",
                     got.res, {got.ovf, got.unf, got.zero}, got.lat);
        end
        release_op();
    endtask

    task automatic test_random();
        exp_t        got, ex;
        logic        t_en, t_mode;
        logic [4:0]  t_amt;
        logic [26:0] t_nm;
        logic        s, c;
        logic [7:0]  e;
        logic [26:0] mt, mask;
        int          k;
        for (int n = 0; n < 300; n++) begin
            s = 1'($urandom);
            c = 1'($urandom);
            e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30))
                                            : 8'($urandom_range(0, 254));
            k    = $urandom_range(0, 27);
            mask = 27'((64'd1 << (27 - k)) - 64'd1);
            mt   = 27'($urandom) & mask;
            if ($urandom_range(0, 7) == 0) mt = 27'h7FFFFFF - 27'($urandom_range(0, 15));
            ex = ref_model(s, e, c, mt);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 2) == 0);
            run_op(s, e, c, mt, got, t_en, t_mode, t_amt, t_nm);
            checks++;
            if (got.res !== ex.res) begin
                errors++;
                $display("FAIL rnd%0d_result: in s=%b e=%0d c=%b m=%h got %h required %h",
                         n, s, e, c, mt, got.res, ex.res);
            end
            checks++;
            if ({got.ovf, got.unf, got.zero} !== {ex.ovf, ex.unf, ex.zero}) begin
                errors++;
                $display("FAIL rnd%0d_flags: got %b required %b", n,
                         {got.ovf, got.unf, got.zero}, {ex.ovf, ex.unf, ex.zero});
            end
            checks++;
            if (got.lat !== ex.lat) begin
                errors++;
                $display("FAIL rnd%0d_latency: got %0d required %0d", n, got.lat, ex.lat);
            end
            if (!out_ready) repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            release_op();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
